// File: rtl/sph_accumulator.sv
// SPH pair-term accumulator: sums per-particle terms, builds pressure and 1/rho tables, emits force sums.
// Optional sticky saturation indicator enabled by defining SPH_ACCUM_SAT_FLAG_EN.
module sph_accumulator #(
  parameter int PARTICLE_COUNT = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter logic [DATA_WIDTH-1:0] REST_DENSITY = 16'h0200,
  parameter logic [DATA_WIDTH-1:0] K_STIFF = 16'h0100,
  localparam int IW = (PARTICLE_COUNT > 1) ? $clog2(PARTICLE_COUNT) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  next_sum,
  input  logic                  is_density_task,
  input  logic [IW-1:0]         main_index,
  input  logic                  term_valid,
  input  logic [DATA_WIDTH-1:0] term_data,
  input  logic [IW-1:0]         req_index,
  output logic [DATA_WIDTH-1:0] density_reciprocal,
  output logic [DATA_WIDTH-1:0] pressure,
  output logic                  done_accumulating,
  output logic [DATA_WIDTH-1:0] force_sum,
`ifdef SPH_ACCUM_SAT_FLAG_EN
  output logic                  force_valid,
  output logic                  sat_flag
`else
  output logic                  force_valid
`endif
);
  localparam int DW  = DATA_WIDTH;
  localparam int AW  = DW + IW;
  localparam int CW  = $clog2(PARTICLE_COUNT + 1);
  localparam int DCW = $clog2(DW + 2);
  localparam logic signed [AW-1:0]   ACC_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0]   ACC_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [2*DW-1:0] P_MAX   = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW-1:0] P_MIN   = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW:0]            NUM_INIT = (DW+1)'(1) << (2*FRAC_BITS);
  localparam logic [DW-1:0]          W_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]          W_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} state_t;

  state_t                state_q, state_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  density_q, density_d;
  logic [IW-1:0]         index_q, index_d;
  logic                  force_pend_q, force_pend_d;
  logic [DCW-1:0]        div_cnt_q, div_cnt_d;
  logic [DW-1:0]         rho_q, rho_d;
  logic [DW-1:0]         rem_q, rem_d;
  logic [DW:0]           num_q, num_d;
  logic [DW:0]           quot_q, quot_d;
  logic [DW-1:0]         p_tab_q [PARTICLE_COUNT];
  logic [DW-1:0]         p_tab_d [PARTICLE_COUNT];
  logic [DW-1:0]         r_tab_q [PARTICLE_COUNT];
  logic [DW-1:0]         r_tab_d [PARTICLE_COUNT];
  logic [DW-1:0]         recip_q, recip_d, press_q, press_d, force_q, force_d;
  logic                  done_q, done_d, fvalid_q, fvalid_d;

  logic [DW-1:0]         sat_acc, rho_now, p_val, r_val;
  logic [DW:0]           rem_shift;
  logic signed [2*DW-1:0] diff_w, prod_w, shr_w;
  logic                  rho_load, tab_write;

  always_comb begin
    if (acc_q > ACC_MAX)      sat_acc = W_MAX;
    else if (acc_q < ACC_MIN) sat_acc = W_MIN;
    else                      sat_acc = acc_q[DW-1:0];
  end

  // Pressure uses a full double-width product so the shift sees every bit before saturation.
  always_comb begin
    diff_w = $signed({{DW{rho_q[DW-1]}}, rho_q}) - $signed({{DW{REST_DENSITY[DW-1]}}, REST_DENSITY});
    prod_w = diff_w * $signed({{DW{K_STIFF[DW-1]}}, K_STIFF});
    shr_w  = prod_w >>> FRAC_BITS;
    if (shr_w > P_MAX)      p_val = W_MAX;
    else if (shr_w < P_MIN) p_val = W_MIN;
    else                    p_val = shr_w[DW-1:0];
    if (rho_q[DW-1] || rho_q == '0 || quot_q[DW:DW-1] != 2'b00) r_val = W_MAX;
    else                                                       r_val = quot_q[DW-1:0];
  end

  assign rho_now   = (div_cnt_q == '0) ? sat_acc : rho_q;
  assign rem_shift = {rem_q, num_q[DW]};
  assign rho_load  = (state_q == DIVIDE) && (div_cnt_q == '0);
  assign tab_write = (state_q == DIVIDE) && (div_cnt_q == DCW'(DW + 1)) && !next_sum;

  always_comb begin
    state_d = state_q; acc_d = acc_q; cnt_d = cnt_q;
    density_d = density_q; index_d = index_q; force_pend_d = force_pend_q;
    div_cnt_d = div_cnt_q; rho_d = rho_q; rem_d = rem_q; num_d = num_q; quot_d = quot_q;
    p_tab_d = p_tab_q; r_tab_d = r_tab_q;
    force_d = force_q; done_d = done_q; fvalid_d = 1'b0;
    recip_d = '0; press_d = '0;
    case (state_q)
      ACCUM: if (term_valid && !next_sum) begin
        acc_d = acc_q + {{IW{term_data[DW-1]}}, term_data};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(PARTICLE_COUNT - 1)) begin
          if (density_q) begin
            state_d = DIVIDE; div_cnt_d = '0; rem_d = '0; num_d = NUM_INIT; quot_d = '0;
          end else begin
            state_d = DONE; force_pend_d = 1'b1;
          end
        end
      end
      DIVIDE: begin
        if (rho_load) rho_d = sat_acc;
        // Restoring division, one quotient bit per cycle; non-positive rho skips the work.
        if (div_cnt_q <= DCW'(DW)) begin
          if (!rho_now[DW-1] && rho_now != '0) begin
            if (rem_shift >= {1'b0, rho_now}) begin
              rem_d = rem_shift[DW-1:0] - rho_now; quot_d = {quot_q[DW-1:0], 1'b1};
            end else begin
              rem_d = rem_shift[DW-1:0]; quot_d = {quot_q[DW-1:0], 1'b0};
            end
          end
          num_d = num_q << 1;
          div_cnt_d = div_cnt_q + 1'b1;
        end else if (tab_write) begin
          if (int'(index_q) < PARTICLE_COUNT) begin
            p_tab_d[index_q] = p_val; r_tab_d[index_q] = r_val;
          end
          done_d = 1'b1; state_d = DONE;
        end
      end
      default: ;
    endcase
    if (force_pend_q) begin
      force_d = sat_acc; fvalid_d = 1'b1; done_d = 1'b1; force_pend_d = 1'b0;
    end
    if (next_sum) begin
      state_d = ACCUM; acc_d = '0; cnt_d = '0; done_d = 1'b0;
      density_d = is_density_task; index_d = main_index;
    end
    if (int'(req_index) < PARTICLE_COUNT) begin
      recip_d = r_tab_q[req_index]; press_d = p_tab_q[req_index];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE; acc_q <= '0; cnt_q <= '0; density_q <= 1'b0; index_q <= '0;
      force_pend_q <= 1'b0; div_cnt_q <= '0; rho_q <= '0; rem_q <= '0; num_q <= '0; quot_q <= '0;
      for (int i = 0; i < PARTICLE_COUNT; i++) begin
        p_tab_q[i] <= '0; r_tab_q[i] <= '0;
      end
      recip_q <= '0; press_q <= '0; force_q <= '0; done_q <= 1'b0; fvalid_q <= 1'b0;
    end else begin
      state_q <= state_d; acc_q <= acc_d; cnt_q <= cnt_d; density_q <= density_d; index_q <= index_d;
      force_pend_q <= force_pend_d; div_cnt_q <= div_cnt_d; rho_q <= rho_d; rem_q <= rem_d;
      num_q <= num_d; quot_q <= quot_d; p_tab_q <= p_tab_d; r_tab_q <= r_tab_d;
      recip_q <= recip_d; press_q <= press_d; force_q <= force_d; done_q <= done_d; fvalid_q <= fvalid_d;
    end
  end

`ifdef SPH_ACCUM_SAT_FLAG_EN
  logic sat_q, sat_d, acc_hit, p_hit, r_hit;
  assign acc_hit = (acc_q > ACC_MAX) || (acc_q < ACC_MIN);
  assign p_hit   = (shr_w > P_MAX) || (shr_w < P_MIN);
  assign r_hit   = rho_q[DW-1] || (rho_q == '0) || (quot_q[DW:DW-1] != 2'b00);
  assign sat_d   = sat_q | ((rho_load || force_pend_q) && acc_hit) | (tab_write && (p_hit || r_hit));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) sat_q <= 1'b0;
    else         sat_q <= sat_d;
  end
  assign sat_flag = sat_q;
`endif

  assign density_reciprocal = recip_q;
  assign pressure           = press_q;
  assign done_accumulating  = done_q;
  assign force_sum          = force_q;
  assign force_valid        = fvalid_q;
endmodule
